// File: rtl/warp_mem_arbiter_if.sv
// Signal bundle between warp_mem_arbiter, its two requesters and the memory port.
// The arbiter takes the slave view; the surrounding blocks take the master view.
interface warp_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 39,
    parameter int DATA_WIDTH = 64
);
    localparam int MASK_WIDTH = DATA_WIDTH / 8;

    logic                  i_flush;

    logic                  i_if_req;
    logic [ADDR_WIDTH-1:0] i_if_addr;
    logic                  o_if_gnt;
    logic                  o_if_valid;
    logic [DATA_WIDTH-1:0] o_if_rdata;

    logic                  i_ls_req;
    logic                  i_ls_wen;
    logic [ADDR_WIDTH-1:0] i_ls_addr;
    logic [DATA_WIDTH-1:0] i_ls_wdata;
    logic [MASK_WIDTH-1:0] i_ls_wmask;
    logic                  o_ls_gnt;
    logic                  o_ls_valid;
    logic [DATA_WIDTH-1:0] o_ls_rdata;

    logic                  o_mem_req;
    logic                  o_mem_wen;
    logic [ADDR_WIDTH-1:0] o_mem_addr;
    logic [DATA_WIDTH-1:0] o_mem_wdata;
    logic [MASK_WIDTH-1:0] o_mem_wmask;
    logic                  i_mem_ready;
    logic                  i_mem_valid;
    logic [DATA_WIDTH-1:0] i_mem_rdata;

    modport slave (
        input  i_flush,
        input  i_if_req, i_if_addr,
        output o_if_gnt, o_if_valid, o_if_rdata,
        input  i_ls_req, i_ls_wen, i_ls_addr, i_ls_wdata, i_ls_wmask,
        output o_ls_gnt, o_ls_valid, o_ls_rdata,
        output o_mem_req, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_wmask,
        input  i_mem_ready, i_mem_valid, i_mem_rdata
    );

    modport master (
        output i_flush,
        output i_if_req, i_if_addr,
        input  o_if_gnt, o_if_valid, o_if_rdata,
        output i_ls_req, i_ls_wen, i_ls_addr, i_ls_wdata, i_ls_wmask,
        input  o_ls_gnt, o_ls_valid, o_ls_rdata,
        input  o_mem_req, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_wmask,
        output i_mem_ready, i_mem_valid, i_mem_rdata
    );
endinterface

// File: rtl/warp_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and LSU, with a single
// outstanding transaction and flush-based discard of in-flight fetch responses.
module warp_mem_arbiter #(
    parameter int ADDR_WIDTH = 39,
    parameter int DATA_WIDTH = 64
) (
    input logic               i_clk,
    input logic               i_rst_n,
    warp_mem_arbiter_if.slave bus
);
    localparam int MASK_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;
    typedef enum logic {OWN_FETCH = 1'b0, OWN_LSU = 1'b1} owner_e;

    state_e                state_q, state_d;
    owner_e                owner_q, owner_d;
    owner_e                last_owner_q, last_owner_d;
    logic                  kill_q, kill_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  wen_q, wen_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [MASK_WIDTH-1:0] wmask_q, wmask_d;
    logic                  if_valid_q, if_valid_d;
    logic                  ls_valid_q, ls_valid_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] ls_rdata_q, ls_rdata_d;
    logic                  if_gnt, ls_gnt;
    logic                  if_req_m;
    logic                  fetch_flush;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_FETCH;
            last_owner_q <= OWN_FETCH;
            kill_q       <= 1'b0;
            addr_q       <= '0;
            wen_q        <= 1'b0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            if_valid_q   <= 1'b0;
            ls_valid_q   <= 1'b0;
            if_rdata_q   <= '0;
            ls_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            kill_q       <= kill_d;
            addr_q       <= addr_d;
            wen_q        <= wen_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
            if_valid_q   <= if_valid_d;
            ls_valid_q   <= ls_valid_d;
            if_rdata_q   <= if_rdata_d;
            ls_rdata_q   <= ls_rdata_d;
        end
    end

    // A flush while idle only suppresses the fetch request; once a fetch is
    // outstanding it marks the transaction killed instead.
    assign if_req_m    = bus.i_if_req & ~bus.i_flush;
    assign fetch_flush = bus.i_flush & (owner_q == OWN_FETCH);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        kill_d       = kill_q;
        addr_d       = addr_q;
        wen_d        = wen_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;
        if_valid_d   = 1'b0;
        ls_valid_d   = 1'b0;
        if_rdata_d   = if_rdata_q;
        ls_rdata_d   = ls_rdata_q;
        if_gnt       = 1'b0;
        ls_gnt       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.i_ls_req && (!if_req_m || last_owner_q == OWN_FETCH)) begin
                    ls_gnt       = 1'b1;
                    owner_d      = OWN_LSU;
                    last_owner_d = OWN_LSU;
                    kill_d       = 1'b0;
                    addr_d       = bus.i_ls_addr;
                    wen_d        = bus.i_ls_wen;
                    wdata_d      = bus.i_ls_wdata;
                    wmask_d      = bus.i_ls_wmask;
                    state_d      = S_REQ;
                end else if (if_req_m) begin
                    if_gnt       = 1'b1;
                    owner_d      = OWN_FETCH;
                    last_owner_d = OWN_FETCH;
                    kill_d       = 1'b0;
                    addr_d       = bus.i_if_addr;
                    wen_d        = 1'b0;
                    wdata_d      = '0;
                    wmask_d      = '0;
                    state_d      = S_REQ;
                end
            end
            S_REQ: begin
                if (fetch_flush) kill_d = 1'b1;
                if (bus.i_mem_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (fetch_flush) kill_d = 1'b1;
                if (bus.i_mem_valid) begin
                    state_d = S_IDLE;
                    if (owner_q == OWN_LSU) begin
                        ls_rdata_d = bus.i_mem_rdata;
                        ls_valid_d = 1'b1;
                    end else if (!(kill_q || bus.i_flush)) begin
                        if_rdata_d = bus.i_mem_rdata;
                        if_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.o_if_gnt    = if_gnt;
    assign bus.o_ls_gnt    = ls_gnt;
    assign bus.o_if_valid  = if_valid_q;
    assign bus.o_ls_valid  = ls_valid_q;
    assign bus.o_if_rdata  = if_rdata_q;
    assign bus.o_ls_rdata  = ls_rdata_q;
    assign bus.o_mem_req   = (state_q == S_REQ);
    assign bus.o_mem_wen   = wen_q;
    assign bus.o_mem_addr  = addr_q;
    assign bus.o_mem_wdata = wdata_q;
    assign bus.o_mem_wmask = wmask_q;
endmodule

// File: tb/tb_warp_mem_arbiter.sv
// Directed bench for warp_mem_arbiter: a memory model consumes expected transactions
// from a queue and pushes expected responses onto a scoreboard checked at the outputs.
module tb_warp_mem_arbiter;
    localparam int AW = 39;
    localparam int DW = 64;
    localparam int MW = DW / 8;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;
    int   cyc_n   = 0;
    int   n_vec   = 0;
    int   n_err   = 0;
    int   mph     = 0;

    typedef struct {
        logic          lsu;
        logic [AW-1:0] addr;
        logic          wen;
        logic [DW-1:0] wdata;
        logic [MW-1:0] wmask;
        int            stall;
        int            lat;
        logic [DW-1:0] rdata;
        logic          killed;
    } tx_t;

    typedef struct {
        logic          lsu;
        logic [DW-1:0] rdata;
        logic          chkd;
        int            cyc;
    } rsp_t;

    tx_t  txq[$];
    rsp_t sbq[$];
    rsp_t mon_r;

    warp_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    warp_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .bus    (bus)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic tx_t mk(input logic lsu, input logic [AW-1:0] a, input logic w,
                               input logic [DW-1:0] wd, input logic [MW-1:0] wm,
                               input int st, input int lt, input logic [DW-1:0] rd,
                               input logic k);
        tx_t t;
        t.lsu = lsu; t.addr = a; t.wen = w; t.wdata = wd; t.wmask = wm;
        t.stall = st; t.lat = lt; t.rdata = rd; t.killed = k;
        return t;
    endfunction

    // Memory model: ready after 'stall' REQ cycles, valid 'lat' cycles after acceptance.
    initial begin : mem_model
        tx_t cur;
        int  cnt;
        cnt = 0;
        bus.i_mem_ready = 1'b0;
        bus.i_mem_valid = 1'b0;
        bus.i_mem_rdata = '0;
        forever begin
            @(posedge i_clk);
            #1;
            bus.i_mem_ready = 1'b0;
            bus.i_mem_valid = 1'b0;
            if (!i_rst_n) begin
                mph = 0;
            end else begin
                if (mph == 0 && bus.o_mem_req) begin
                    if (txq.size() == 0) chk("mem_req_unexpected", 64'(bus.o_mem_req), 64'd0);
                    else begin
                        cur = txq.pop_front();
                        mph = 1;
                    end
                end
                if (mph == 1) begin
                    chk("mem_req_held", 64'(bus.o_mem_req), 64'd1);
                    chk("mem_addr", 64'(bus.o_mem_addr), 64'(cur.addr));
                    chk("mem_wen", 64'(bus.o_mem_wen), 64'(cur.wen));
                    chk("mem_wmask", 64'(bus.o_mem_wmask), 64'(cur.wmask));
                    if (cur.wen) chk("mem_wdata", bus.o_mem_wdata, cur.wdata);
                    if (cur.stall > 0) cur.stall--;
                    else begin
                        bus.i_mem_ready = 1'b1;
                        cnt = cur.lat;
                        mph = 2;
                    end
                end else if (mph == 2) begin
                    chk("mem_req_in_wait", 64'(bus.o_mem_req), 64'd0);
                    cnt--;
                    if (cnt == 0) begin
                        bus.i_mem_valid = 1'b1;
                        bus.i_mem_rdata = cur.rdata;
                        if (!cur.killed) sbq.push_back('{cur.lsu, cur.rdata, !cur.wen, cyc_n + 1});
                        mph = 0;
                    end
                end
            end
        end
    end

    // Response monitor and grant exclusivity, sampled mid-cycle.
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            chk("gnt_onehot", 64'(bus.o_if_gnt & bus.o_ls_gnt), 64'd0);
            if (bus.o_if_valid || bus.o_ls_valid) begin
                if (sbq.size() == 0)
                    chk("valid_unexpected", 64'({bus.o_ls_valid, bus.o_if_valid}), 64'd0);
                else begin
                    mon_r = sbq.pop_front();
                    chk("rsp_if_valid", 64'(bus.o_if_valid), 64'(!mon_r.lsu));
                    chk("rsp_ls_valid", 64'(bus.o_ls_valid), 64'(mon_r.lsu));
                    chk("rsp_cycle", 64'(cyc_n), 64'(mon_r.cyc));
                    if (mon_r.chkd)
                        chk("rsp_rdata", mon_r.lsu ? bus.o_ls_rdata : bus.o_if_rdata, mon_r.rdata);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic expect_gnt(input string tag, input logic e_if, input logic e_ls);
        #1;
        chk({tag, "_if_gnt"}, 64'(bus.o_if_gnt), 64'(e_if));
        chk({tag, "_ls_gnt"}, 64'(bus.o_ls_gnt), 64'(e_ls));
    endtask

    task automatic drain(input string tag);
        int k;
        for (k = 0; k < 60; k++) begin
            if (txq.size() == 0 && sbq.size() == 0 && mph == 0) break;
            cyc();
        end
        chk({tag, "_drain"}, 64'(txq.size() + sbq.size() + mph), 64'd0);
        cyc();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_if_gnt"}, 64'(bus.o_if_gnt), 64'd0);
        chk({tag, "_ls_gnt"}, 64'(bus.o_ls_gnt), 64'd0);
        chk({tag, "_if_valid"}, 64'(bus.o_if_valid), 64'd0);
        chk({tag, "_ls_valid"}, 64'(bus.o_ls_valid), 64'd0);
        chk({tag, "_if_rdata"}, bus.o_if_rdata, 64'd0);
        chk({tag, "_ls_rdata"}, bus.o_ls_rdata, 64'd0);
        chk({tag, "_mem_req"}, 64'(bus.o_mem_req), 64'd0);
        chk({tag, "_mem_wen"}, 64'(bus.o_mem_wen), 64'd0);
        chk({tag, "_mem_addr"}, 64'(bus.o_mem_addr), 64'd0);
        chk({tag, "_mem_wdata"}, bus.o_mem_wdata, 64'd0);
        chk({tag, "_mem_wmask"}, 64'(bus.o_mem_wmask), 64'd0);
    endtask

    initial begin : stim
        int c0;
        bus.i_flush = 1'b0;
        bus.i_if_req = 1'b0; bus.i_if_addr = '0;
        bus.i_ls_req = 1'b0; bus.i_ls_wen = 1'b0; bus.i_ls_addr = '0;
        bus.i_ls_wdata = '0; bus.i_ls_wmask = '0;

        cyc(); cyc();
        check_zero("reset");
        i_rst_n = 1'b1;

        // Contention from reset: LSU first, then alternating, grants 4 cycles apart.
        cyc();
        txq.push_back(mk(1, 39'h200, 0, '0, 8'hFF, 0, 2, 64'h1111_0000_0000_0001, 0));
        txq.push_back(mk(0, 39'h1000, 0, '0, 8'h00, 0, 2, 64'h2222_0000_0000_0002, 0));
        txq.push_back(mk(1, 39'h200, 0, '0, 8'hFF, 0, 2, 64'h3333_0000_0000_0003, 0));
        txq.push_back(mk(0, 39'h1000, 0, '0, 8'h00, 0, 2, 64'h4444_0000_0000_0004, 0));
        bus.i_if_req = 1'b1; bus.i_if_addr = 39'h1000;
        bus.i_ls_req = 1'b1; bus.i_ls_wen = 1'b0; bus.i_ls_addr = 39'h200; bus.i_ls_wmask = 8'hFF;
        for (int g = 0; g < 4; g++) begin
            expect_gnt($sformatf("cont%0d", g), g[0], !g[0]);
            if (g < 3) begin
                for (int k = 0; k < 3; k++) begin
                    cyc();
                    expect_gnt($sformatf("cont%0d_gap%0d", g, k), 1'b0, 1'b0);
                end
                cyc();
            end
        end
        cyc();
        bus.i_if_req = 1'b0; bus.i_ls_req = 1'b0;
        drain("cont");

        // Fetch alone: grant c0, req c1 only, valid c4.
        c0 = cyc_n;
        txq.push_back(mk(0, 39'h40_0000_0000, 0, '0, 8'h00, 0, 2, 64'hDEADBEEF00000013, 0));
        bus.i_if_req = 1'b1; bus.i_if_addr = 39'h40_0000_0000;
        expect_gnt("fa", 1'b1, 1'b0);
        cyc(); bus.i_if_req = 1'b0; #1;
        chk("fa_req_c1", 64'(bus.o_mem_req), 64'd1);
        cyc(); #1;
        chk("fa_req_c2", 64'(bus.o_mem_req), 64'd0);
        cyc(); cyc(); #1;
        chk("fa_valid_cycle", 64'(cyc_n - c0), 64'd4);
        chk("fa_if_valid_c4", 64'(bus.o_if_valid), 64'd1);
        chk("fa_if_rdata_c4", bus.o_if_rdata, 64'hDEADBEEF00000013);
        drain("fa");

        // LSU write with 3 stall cycles; requester inputs change after grant.
        txq.push_back(mk(1, 39'h100, 1, 64'h1122334455667788, 8'h0F, 3, 2, 64'h5A5A_5A5A_5A5A_5A5A, 0));
        bus.i_ls_req = 1'b1; bus.i_ls_wen = 1'b1; bus.i_ls_addr = 39'h100;
        bus.i_ls_wdata = 64'h1122334455667788; bus.i_ls_wmask = 8'h0F;
        expect_gnt("lw", 1'b0, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            cyc();
            if (k == 1) begin
                bus.i_ls_req = 1'b0; bus.i_ls_wen = 1'b0; bus.i_ls_addr = 39'h7FF;
                bus.i_ls_wdata = '0; bus.i_ls_wmask = 8'hF0;
            end
            #1;
            chk($sformatf("lw_req_c%0d", k), 64'(bus.o_mem_req), 64'(k <= 4));
            if (k <= 4) chk($sformatf("lw_wen_c%0d", k), 64'(bus.o_mem_wen), 64'd1);
        end
        drain("lw");

        // Flush in IDLE with both requesting: fetch masked even though it is its turn.
        txq.push_back(mk(1, 39'h300, 0, '0, 8'hFF, 0, 2, 64'h0BAD_F00D_0000_0300, 0));
        bus.i_flush = 1'b1;
        bus.i_if_req = 1'b1; bus.i_if_addr = 39'h3000;
        bus.i_ls_req = 1'b1; bus.i_ls_wen = 1'b0; bus.i_ls_addr = 39'h300; bus.i_ls_wmask = 8'hFF;
        expect_gnt("fi", 1'b0, 1'b1);
        cyc();
        bus.i_flush = 1'b0; bus.i_if_req = 1'b0; bus.i_ls_req = 1'b0;
        drain("fi");

        // Flush in WAIT: response consumed, no fetch valid, fetch rdata unchanged.
        txq.push_back(mk(0, 39'h2000, 0, '0, 8'h00, 0, 4, 64'hBADBADBADBADBAD0, 1));
        bus.i_if_req = 1'b1; bus.i_if_addr = 39'h2000;
        expect_gnt("fw", 1'b1, 1'b0);
        cyc(); bus.i_if_req = 1'b0;
        cyc(); bus.i_flush = 1'b1;
        cyc(); bus.i_flush = 1'b0;
        drain("fw");
        cyc(); cyc(); #1;
        chk("fw_if_rdata_kept", bus.o_if_rdata, 64'hDEADBEEF00000013);

        txq.push_back(mk(0, 39'h40, 0, '0, 8'h00, 0, 2, 64'h0000_0040_CAFE_0001, 0));
        bus.i_if_req = 1'b1; bus.i_if_addr = 39'h40;
        expect_gnt("fn", 1'b1, 1'b0);
        cyc(); bus.i_if_req = 1'b0;
        drain("fn");
        chk("fn_if_rdata", bus.o_if_rdata, 64'h0000_0040_CAFE_0001);

        // Reset during WAIT: outputs clear at once, response lost, then a fresh fetch.
        txq.push_back(mk(0, 39'h80, 0, '0, 8'h00, 0, 5, 64'h7777_7777_7777_7777, 1));
        bus.i_if_req = 1'b1; bus.i_if_addr = 39'h80;
        expect_gnt("rm", 1'b1, 1'b0);
        cyc(); bus.i_if_req = 1'b0;
        cyc(); #2;
        i_rst_n = 1'b0;
        #1;
        check_zero("rst_mid");
        cyc(); cyc();
        i_rst_n = 1'b1;
        for (int k = 0; k < 8; k++) cyc();
        chk("rm_no_mem_req", 64'(bus.o_mem_req), 64'd0);

        c0 = cyc_n;
        txq.push_back(mk(0, 39'hC0, 0, '0, 8'h00, 0, 2, 64'h0123_4567_89AB_CDEF, 0));
        bus.i_if_req = 1'b1; bus.i_if_addr = 39'hC0;
        expect_gnt("rf", 1'b1, 1'b0);
        cyc(); bus.i_if_req = 1'b0;
        cyc(); cyc(); cyc(); #1;
        chk("rf_valid_cycle", 64'(cyc_n - c0), 64'd4);
        chk("rf_if_valid_c4", 64'(bus.o_if_valid), 64'd1);
        chk("rf_if_rdata_c4", bus.o_if_rdata, 64'h0123_4567_89AB_CDEF);
        drain("rf");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/warp_mem_arbiter.md
# warp_mem_arbiter

Arbiter sharing one hart-side memory port between the instruction fetch unit and the load/store unit. It sits between `warp_fetch`, the LSU and the memory interface. It grants one requester at a time, round-robin when both contend, and registers the winner's request onto the memory port. It tracks a single outstanding transaction and routes the registered response back to its owner. A pipeline flush can discard an in-flight fetch response.

## Interface
- `ADDR_WIDTH`, 39: physical address width.
- `DATA_WIDTH`, 64: data width; mask width is `DATA_WIDTH/8`.

- `i_clk` in 1: clock.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_flush` in 1: pipeline flush; kills the pending or in-flight fetch transaction.
- `i_if_req` in 1: fetch read request; held until granted.
- `i_if_addr` in `ADDR_WIDTH`: fetch address.
- `o_if_gnt` out 1: fetch request accepted this cycle.
- `o_if_valid` out 1: fetch response valid, one-cycle pulse.
- `o_if_rdata` out `DATA_WIDTH`: fetch response data.
- `i_ls_req` in 1: LSU request; held until granted.
- `i_ls_wen` in 1: 1 = write, 0 = read.
- `i_ls_addr` in `ADDR_WIDTH`: LSU address.
- `i_ls_wdata` in `DATA_WIDTH`: LSU write data.
- `i_ls_wmask` in `DATA_WIDTH/8`: byte write enables.
- `o_ls_gnt` out 1: LSU request accepted this cycle.
- `o_ls_valid` out 1: LSU response or write ack, one-cycle pulse.
- `o_ls_rdata` out `DATA_WIDTH`: LSU read data; undefined for writes.
- `o_mem_req` out 1: memory request valid.
- `o_mem_wen` out 1: memory write enable.
- `o_mem_addr` out `ADDR_WIDTH`: memory address.
- `o_mem_wdata` out `DATA_WIDTH`: memory write data.
- `o_mem_wmask` out `DATA_WIDTH/8`: memory byte mask.
- `i_mem_ready` in 1: memory accepts the request this cycle.
- `i_mem_valid` in 1: memory response valid; arrives no earlier than the cycle after acceptance.
- `i_mem_rdata` in `DATA_WIDTH`: memory response data.

## Operation
- FSM states: IDLE, REQ, WAIT. The `owner` register (FETCH/LSU) and the `kill` bit qualify the transaction.
- **IDLE, arbitration:**
  - One requester active: grant it.
  - Both active: grant the one that is not `last_owner`.
  - `last_owner` resets to FETCH, so the LSU wins the first contention.
  - `i_flush` high in IDLE masks `i_if_req`; no fetch grant that cycle.
- **On grant:**
  - `o_x_gnt` is combinational, asserted in the IDLE cycle.
  - Address, wen, wdata and wmask are latched into registers. Fetch forces `wen=0` and `wmask=0`.
  - `owner` and `last_owner` update; `kill` clears; next state is REQ.
- **REQ:** `o_mem_req=1` with the registered fields held stable. When `i_mem_ready=1`, go to WAIT.
- **WAIT:** when `i_mem_valid=1`:
  - Register `i_mem_rdata` into the owner's rdata output.
  - Pulse the owner's valid output next cycle, unless `owner=FETCH` and `kill` is set.
  - Next state is IDLE.
- **Flush:** `i_flush` while in REQ or WAIT with `owner=FETCH` sets `kill`.
  - The memory transaction still completes, but `o_if_valid` stays 0.
  - `o_if_rdata` is not updated.
  - LSU transactions are never affected by flush.
- **Protocol violations:** `i_mem_valid` in IDLE or REQ is ignored. `i_mem_ready` outside REQ is ignored.
- Granted requesters may drop or change their request inputs from the cycle after grant.

## Timing
- **Reset values:** state IDLE, `owner` FETCH, `last_owner` FETCH, `kill` 0. Every output is 0: all gnt/valid/req bits, `o_mem_addr`, `o_mem_wdata`, `o_mem_wmask`, `o_mem_wen`, `o_if_rdata`, `o_ls_rdata`.
- **Reset mid-transaction:** all state clears immediately and the outstanding response is lost. The memory is reset by the same `i_rst_n`.
- **Latency:** request and grant occur in cycle 0. `o_mem_req` is high from cycle 1 until ready. With ready in cycle 1 and valid in cycle N≥2, `o_x_valid` pulses in cycle N+1.
- In cycle N+1 the FSM is back in IDLE and can grant again. Minimum cycles between back-to-back grants: 3.
- `o_mem_req` holds high across `i_mem_ready=0` stall cycles with all fields constant.
- Valid outputs are registered and high for exactly one cycle. Rdata outputs hold their value until the next update of the same owner.
- At most one of `o_if_gnt` / `o_ls_gnt` is high in any cycle, and only in IDLE.

## Test plan
- **Fetch alone:** `i_if_addr=0x4000000000`; ready in cycle 1, valid in cycle 3 with rdata `0xDEADBEEF00000013`.
  - Required: `o_if_gnt` in cycle 0, `o_mem_req` in cycles 1–1, `o_if_valid` in cycle 4 with that rdata.
  - `o_ls_valid` stays 0 throughout.
- **Contention from reset:** both request in cycle 0.
  - Required: LSU granted first. Fetch is granted in the first IDLE cycle after the LSU response, then the order alternates while both stay requesting.
- **LSU write:** `addr=0x100`, `wdata=0x1122334455667788`, `wmask=0x0F`, ready stalled 3 cycles.
  - Required: `o_mem_req` is high 4 cycles with `o_mem_wen=1` and all fields stable.
  - `o_ls_valid` pulses once, one cycle after `i_mem_valid`.
- **Flush in WAIT:** fetch in flight, `i_flush` pulsed in WAIT.
  - Required: memory response consumed; `o_if_valid` never asserts; `o_if_rdata` unchanged.
  - The next fetch to `0x40` completes normally.
- **Flush in IDLE:** `i_flush` high with `i_if_req` and `i_ls_req` both high.
  - Required: only `o_ls_gnt` asserts that cycle.
- **Reset mid-transaction:** assert `i_rst_n=0` during WAIT.
  - Required: all outputs go to 0 asynchronously and no valid pulse follows. After release, a fresh fetch completes with the standard latency.
